regfile_loader: RTL and testbench

//  Initiator for the register-file write and read ports. On a start pulse it

---
 rtl/regfile_loader.sv | 100 ++++++++++
 tb/tb_regfile_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/regfile_loader.sv
// regfile_loader: streams one word into each of registers 1..NREG-1, then
// reads back registers 0..NREG-1 and compares the sum against the load-time
// checksum. It also confirms that register 0 reads as zero.
module regfile_loader #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               regwrite,
    output logic [REGBITS-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic [REGBITS-1:0] ra,
    input  logic [WIDTH-1:0]   rd,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [WIDTH-1:0]   checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    localparam logic [REGBITS-1:0] LAST = '1;

    state_t             state, state_nx;
    // One counter serves both phases: it wraps from NREG-1 to 0 at the final
    // load, which is exactly where the read-back sweep begins.
    logic [REGBITS-1:0] addr;
    logic [WIDTH-1:0]   vsum;
    logic               zero_fail;
    logic               hs;

    assign hs = (state == LOAD) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (hs && addr == LAST) state_nx = VERIFY;
            VERIFY:  if (addr == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; write and read ports are held at zero when idle
    always_comb begin
        in_ready = (state == LOAD);
        regwrite = hs;
        wa       = hs ? addr : '0;
        wd       = hs ? in_data : '0;
        ra       = (state == VERIFY) ? addr : '0;
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // Address counter, load checksum, read-back sum and the pass verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            checksum  <= '0;
            vsum      <= '0;
            zero_fail <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr      <= REGBITS'(1);
                    checksum  <= '0;
                    vsum      <= '0;
                    zero_fail <= 1'b0;
                    pass      <= 1'b0;
                end
                LOAD: if (hs) begin
                    addr     <= addr + 1'b1;
                    checksum <= checksum + in_data;
                end
                VERIFY: begin
                    addr <= addr + 1'b1;
                    vsum <= vsum + rd;
                    if (addr == '0 && rd != '0) zero_fail <= 1'b1;
                end
                DONE: pass <= (vsum == checksum) && !zero_fail;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader. It includes a small register-file model
// with fault hooks for a corrupted register and a nonzero register 0.
module tb_regfile_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, in_valid, in_ready, regwrite, busy, done, pass;
    logic [7:0] in_data, wd, rd, checksum;
    logic [2:0] wa, ra;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [8];
    logic [7:0] words [7];
    logic       corrupt3, bad0;

    always #5 clk = ~clk;

    regfile_loader #(.WIDTH(8), .REGBITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .regwrite(regwrite),
        .wa(wa), .wd(wd), .ra(ra), .rd(rd), .busy(busy), .done(done),
        .pass(pass), .checksum(checksum)
    );

    // Register file model: reg0 reads 0 unless the bad0 fault is enabled
    always @(posedge clk)
        if (regwrite) mem[wa] <= (corrupt3 && wa == 3'd3) ? (wd ^ 8'h01) : wd;

    assign rd = (ra == 3'd0) ? (bad0 ? 8'h55 : 8'h00) : mem[ra];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // One full pass: start pulse, stream words[], then check the timing and the result
    task automatic run_pass(input bit toggle, input int exp_done, input logic [7:0] exp_ck,
                            input bit exp_pass, input bit restart);
        int w;
        int dn;
        w  = 0;
        dn = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);                // c0
        for (int n = 1; n <= 40 && dn < 0; n++) begin
            @(negedge clk);            // inside cycle n
            start    = (restart && n == 5);
            in_valid = (w < 7) && (!toggle || (n % 2 == 0));
            in_data  = in_valid ? words[w] : 8'h00;
            #1;
            if (n == 1) chk("busy_c1", busy, 1);
            if (w < 7) begin
                chk("regwrite", regwrite, in_valid);
                if (regwrite) begin
                    chk("wa", wa, w + 1);
                    chk("wd", wd, words[w]);
                    w++;
                end
            end
            if (done) dn = n;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        chk("done_cycle", dn, exp_done);
        chk("writes", w, 7);
        @(negedge clk);
        #1;
        chk("done_low", done, 0);
        chk("busy_low", busy, 0);
        chk("checksum", checksum, exp_ck);
        chk("pass", pass, exp_pass);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        corrupt3 = 1'b0; bad0 = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_ck", checksum, 0);
        chk("rst_ports", {regwrite, wa, wd, ra}, 0);
        rst_n = 1'b1;

        // 1: words 1..7, valid held high
        for (int i = 0; i < 7; i++) words[i] = 8'(i + 1);
        run_pass(1'b0, 16, 8'h1C, 1'b1, 1'b0);

        // 2: seven 0xFF words, so the checksum wraps
        for (int i = 0; i < 7; i++) words[i] = 8'hFF;
        run_pass(1'b0, 16, 8'hF9, 1'b1, 1'b0);

        // 3: reg3 is corrupted after its write
        for (int i = 0; i < 7; i++) words[i] = 8'(i + 1);
        corrupt3 = 1'b1;
        run_pass(1'b0, 16, 8'h1C, 1'b0, 1'b0);
        corrupt3 = 1'b0;

        // 4: reg0 reads 0x55
        bad0 = 1'b1;
        run_pass(1'b0, 16, 8'h1C, 1'b0, 1'b0);
        bad0 = 1'b0;

        // 5: valid toggles 0,1,0,1...; a second start arrives mid-pass
        for (int i = 0; i < 7; i++) words[i] = 8'(8'h10 + i);
        run_pass(1'b1, 23, 8'h85, 1'b1, 1'b1);

        // 6: reset after three writes, then a clean pass
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h21;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            in_data = 8'(8'h20 + n);
        end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ab_ready", in_ready, 0);
        chk("ab_busy", busy, 0);
        chk("ab_ck", checksum, 0);
        chk("ab_ports", {regwrite, wa, wd, ra, done, pass}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) words[i] = 8'(i + 1);
        run_pass(1'b0, 16, 8'h1C, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
